// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multiply/divide engine.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mips_cpu_pkg;

  localparam int WORD_W      = 32;
  localparam int MULDIV_ITER = 32;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [2*WORD_W-1:0] dword_t;

  localparam word_t DIV0_QUOT = 32'hFFFF_FFFF;

  // Encoding is chosen so that bit 1 selects divide and bit 0 selects unsigned.
  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Everything latched at issue that the iteration and sign fixup need later.
  typedef struct packed {
    muldiv_op_t op;
    logic       neg_res;  // negate product / quotient (signed op, operand signs differ)
    logic       neg_rem;  // negate remainder (signed op, negative dividend)
    logic       div0;     // divisor was zero
    word_t      opnd;     // |multiplicand| or |divisor|
  } muldiv_ctx_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return ~op[0];
  endfunction

  // Magnitude of v when treated as signed; 0x80000000 maps to itself, which
  // is the correct unsigned magnitude.
  function automatic word_t abs_word(input word_t v, input logic is_signed);
    return (is_signed && v[WORD_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step of shift-add multiply or restoring divide.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
//
// Ports:
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc     : multiply {partial product hi, remaining multiplier bits}
//             divide   {partial remainder, remaining dividend / quotient bits}
//   opnd    : |multiplicand| or |divisor|
//   acc_nxt : accumulator after this step
module muldiv_step
  import mips_cpu_pkg::*;
(
  input  logic   is_div,
  input  dword_t acc,
  input  word_t  opnd,
  output dword_t acc_nxt
);

  logic [WORD_W:0] mul_sum;
  logic [WORD_W:0] div_part;
  logic [WORD_W:0] div_diff;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole thing right with the carry coming in on top.
    mul_sum  = {1'b0, acc[2*WORD_W-1:WORD_W]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: the shifted remainder needs 33 bits, as 2*rem+1 can exceed 32.
    // The difference sign bit is the (inverted) quotient bit.
    div_part = acc[2*WORD_W-1:WORD_W-1];
    div_diff = div_part - {1'b0, opnd};

    acc_nxt = '0;
    if (is_div) begin
      if (!div_diff[WORD_W])
        acc_nxt = {div_diff[WORD_W-1:0], acc[WORD_W-2:0], 1'b1};
      else
        acc_nxt = {div_part[WORD_W-1:0], acc[WORD_W-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WORD_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine driving the HI/LO write port.
// Latency: start at E0 -> hilo_we between E33 and E34 (E1..E2 for multiplies
//          when MULDIV_FAST_MUL_EN is defined); busy high until the write retires.
// Backpressure: no queueing; start is ignored while busy, cancel aborts anything in flight.
//
// Build option: `define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
//
// Ports:
//   cpu_clk_50M, cpu_rst : clock, async active-high reset
//   start, op            : issue request and operation, sampled in IDLE only
//   src_a, src_b         : rs (multiplicand/dividend), rt (multiplier/divisor)
//   cancel               : pipeline flush
//   busy                 : operation in flight, stalls HI/LO consumers
//   hilo_we, hi_o, lo_o  : one-cycle HI/LO write strobe and data
module muldiv_unit
  import mips_cpu_pkg::*;
#(
  parameter int XLEN  = 32,  // only 32 is supported
  parameter int CNT_W = 6    // must be able to count to XLEN
) (
  input  logic            cpu_clk_50M,
  input  logic            cpu_rst,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  output logic            busy,
  output logic            hilo_we,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  dword_t           acc;
  dword_t           acc_nxt;
  muldiv_ctx_t      ctx;

  word_t  a_abs;
  word_t  b_abs;
  dword_t acc_init;
  dword_t prod_fix;
  word_t  quo;
  word_t  rem;
  word_t  hi_fix;
  word_t  lo_fix;

  assign a_abs = abs_word(src_a, op_is_signed(op));
  assign b_abs = abs_word(src_b, op_is_signed(op));

  // Divide iterates the dividend out of the low half; multiply iterates the
  // multiplier out of the low half.
  assign acc_init = op_is_div(op) ? {{WORD_W{1'b0}}, a_abs}
                                  : {{WORD_W{1'b0}}, b_abs};

`ifdef MULDIV_FAST_MUL_EN
  dword_t fast_prod;
  assign fast_prod = dword_t'(a_abs) * dword_t'(b_abs);
`endif

  muldiv_step u_step (
    .is_div  (op_is_div(ctx.op)),
    .acc     (acc),
    .opnd    (ctx.opnd),
    .acc_nxt (acc_nxt)
  );

  // Sign fixup on the magnitude result. A zero divisor leaves the full
  // dividend magnitude as remainder, so the remainder path already yields
  // src_a; only the quotient needs forcing.
  assign prod_fix = ctx.neg_res ? -acc : acc;
  assign quo      = acc[WORD_W-1:0];
  assign rem      = acc[2*WORD_W-1:WORD_W];

  always_comb begin
    hi_fix = '0;
    lo_fix = '0;
    if (op_is_div(ctx.op)) begin
      lo_fix = ctx.div0 ? DIV0_QUOT : (ctx.neg_res ? -quo : quo);
      hi_fix = ctx.neg_rem ? -rem : rem;
    end else begin
      hi_fix = prod_fix[2*WORD_W-1:WORD_W];
      lo_fix = prod_fix[WORD_W-1:0];
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ctx   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            ctx.op      <= op;
            ctx.neg_res <= op_is_signed(op) & (src_a[XLEN-1] ^ src_b[XLEN-1]);
            ctx.neg_rem <= op_is_signed(op) & src_a[XLEN-1];
            ctx.div0    <= (src_b == '0);
            ctx.opnd    <= op_is_div(op) ? b_abs : a_abs;
            cnt         <= '0;
            acc         <= acc_init;
            state       <= CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!op_is_div(op)) begin
              acc   <= fast_prod;
              state <= ADJ;
            end
`endif
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(MULDIV_ITER - 1))
              state <= ADJ;
          end
        end
        ADJ: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            hi_o  <= hi_fix;
            lo_o  <= lo_fix;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign hilo_we = (state == DONE) & ~cancel;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import mips_cpu_pkg::*;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .busy        (busy),
    .hilo_we     (hilo_we),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Negedges after the issue edge E0 at which hilo_we is first seen.
  function automatic int exp_lat(input muldiv_op_t o);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 2;
`endif
    return 34;
  endfunction

  // Called just after a negedge. Issues one op, waits (bounded) for the write,
  // checks latency, data, strobe width and busy release. poke_at > 0 pulses a
  // bogus start with different operands at that negedge while busy.
  task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int poke_at);
    int n;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge cpu_clk_50M);
    start = 1'b0;
    n = 1;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    while (!hilo_we && n < 100) begin
      @(negedge cpu_clk_50M);
      n++;
      if (poke_at > 0 && n == poke_at) begin
        start = 1'b1; op = DIV; src_a = 32'h0BAD_0BAD; src_b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat(o)));
    check_eq({tag, "_hi"}, 64'(hi_o), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo_o), 64'(el));
    @(negedge cpu_clk_50M);
    check_eq({tag, "_we_1cyc"}, 64'(hilo_we), 64'd0);
    check_eq({tag, "_busy_off"}, 64'(busy), 64'd0);
    check_eq({tag, "_hold_hi"}, 64'(hi_o), 64'(eh));
  endtask

  initial begin
    logic seen_we;
    cpu_rst = 1'b1; start = 1'b0; op = MULTU; src_a = '0; src_b = '0; cancel = 1'b0;
    #5;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_we",   64'(hilo_we), 64'd0);
    check_eq("rst_hi",   64'(hi_o), 64'd0);
    check_eq("rst_lo",   64'(lo_o), 64'd0);
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    @(negedge cpu_clk_50M);

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("mult_min",  MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu_7_2",  DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         0);
    run_op("div_negb",  DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 0);
    run_op("divu_big",  DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, 0);
    run_op("div_zero",  DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0);
    run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0);

    // start and cancel together in IDLE: cancel wins.
    start = 1'b1; cancel = 1'b1; op = DIVU; src_a = 32'd9; src_b = 32'd2;
    @(negedge cpu_clk_50M);
    start = 1'b0; cancel = 1'b0;
    check_eq("start_cancel_busy", 64'(busy), 64'd0);

    // Cancel mid-CALC: no write, outputs keep the div_ovf result.
    start = 1'b1; op = DIVU; src_a = 32'd1000; src_b = 32'd7;
    @(negedge cpu_clk_50M);
    start = 1'b0;
    seen_we = hilo_we;
    repeat (9) begin
      @(negedge cpu_clk_50M);
      seen_we |= hilo_we;
    end
    cancel = 1'b1;
    @(negedge cpu_clk_50M);
    cancel = 1'b0;
    seen_we |= hilo_we;
    check_eq("cancel_busy", 64'(busy), 64'd0);
    check_eq("cancel_no_we", 64'(seen_we), 64'd0);
    check_eq("cancel_hi", 64'(hi_o), 64'd0);
    check_eq("cancel_lo", 64'(lo_o), 64'h8000_0000);

    // Immediate restart, then a start pulse while busy that must be ignored.
    run_op("restart",   DIVU,  32'd100, 32'd3, 32'd1, 32'd33, 0);
    run_op("poke_busy", MULTU, 32'd6,   32'd7, 32'd0, 32'd42, 2);
    run_op("divu_pre",  DIVU,  32'd100, 32'd3, 32'd1, 32'd33, 0);

    // Async reset mid-CALC, checked before any clock edge.
    start = 1'b1; op = DIVU; src_a = 32'd55; src_b = 32'd4;
    @(negedge cpu_clk_50M);
    start = 1'b0;
    repeat (5) @(negedge cpu_clk_50M);
    #2 cpu_rst = 1'b1;
    #2;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_we",   64'(hilo_we), 64'd0);
    check_eq("arst_hi",   64'(hi_o), 64'd0);
    check_eq("arst_lo",   64'(lo_o), 64'd0);
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    @(negedge cpu_clk_50M);
    run_op("post_rst", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide engine that produces the HI/LO write port: hilo_we, hi and lo values. It executes MULT, MULTU, DIV and DIVU issued from the EX stage. It holds busy so the pipeline stalls HI/LO consumers. On completion it pulses a one-cycle write into the HI/LO register.

Parameters:
XLEN, 32, operand width. Only 32 is supported; hi/lo are word_t.
CNT_W, 6, iteration counter width. Must hold XLEN.

Ports:
cpu_clk_50M  input  1  system clock, rising edge.
cpu_rst  input  1  reset, asynchronous, active-high.
start  input  1  issue request; sampled only in IDLE.
op  input  2  muldiv_op_t: MULT, MULTU, DIV, DIVU.
src_a  input  32  rs operand: multiplicand or dividend.
src_b  input  32  rt operand: multiplier or divisor.
cancel  input  1  pipeline flush; aborts the current operation.
busy  output  1  high whenever state != IDLE.
hilo_we  output  1  one-cycle write strobe to HI/LO.
hi_o  output  32  result high word (product[63:32] or remainder).
lo_o  output  32  result low word (product[31:0] or quotient).

Behaviour:
- Async reset: state=IDLE. busy=0, hilo_we=0, hi_o=0, lo_o=0, counter=0, all internal accumulators=0.
- FSM states: IDLE, CALC, ADJ, DONE.
  - IDLE -> CALC on start & ~cancel. Latch op, operand signs, abs(src_a), abs(src_b); counter=0.
  - CALC: one radix-2 step per cycle, 32 cycles.
    - Multiply: shift-add on a 64-bit accumulator.
    - Divide: restoring step on a 64-bit remainder/quotient pair.
    - Go to ADJ when counter==31 on that edge.
  - ADJ: sign correction; write hi_o/lo_o registers. Go to DONE.
  - DONE: go to IDLE next edge.
- hilo_we = (state==DONE) & ~cancel. It is high for exactly one cycle.
- Latency: if start is sampled at edge E0, hilo_we is high between edges E33 and E34. busy is high from after E0 through E34.
- start while busy: ignored, with no effect on the operation in flight.
- Signed rules (MULT, DIV): compute on magnitudes.
  - Product is negated (64-bit two's complement) if operand signs differ.
  - Quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops (MULTU, DIVU): no sign handling.
- Division by zero: still full latency. lo_o=0xFFFFFFFF, hi_o=src_a as issued. No exception.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): lo_o=0x80000000, hi_o=0. This falls out of the 32-bit wrap.
- cancel in CALC, ADJ or DONE: next state IDLE. hilo_we is suppressed in that cycle. hi_o/lo_o keep their last committed values.
- cancel together with start in IDLE: cancel wins and the operation is not started.
- Reset asserted mid-operation: immediate return to reset values; no write occurs.
- hi_o/lo_o change only in ADJ and stay stable while hilo_we is high.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined:
  - MULT/MULTU use a single-cycle 64-bit multiplier. IDLE goes directly to ADJ.
  - hilo_we is high between E1 and E2; busy is high for 2 cycles.
  - Division is unchanged.
- Undefined:
  - Multiply uses the 32-cycle shift-add path.
  - No hardware multiplier is inferred.

Decomposition:
- Add to mips_cpu_pkg:
  - muldiv_op_t enum (MULT=0, MULTU=1, DIV=2, DIVU=3).
  - muldiv_state_t enum.
  - MULDIV_ITER=32.
  - DIV0_QUOT=32'hFFFF_FFFF.
- One natural sub-module: muldiv_step. Combinational single radix-2 step for both multiply and divide, taking the accumulator and operands and returning the next accumulator. It is reused by each CALC cycle.
- FSM, counter, sign fixup and output registers stay in muldiv_unit.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. hilo_we is a single pulse between E33 and E34; busy falls after E34.
2. MULT 0xFFFFFFFD (-3) x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. Repeat under MULDIV_FAST_MUL_EN: same values, hilo_we between E1 and E2.
3. DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 7 / 2 -> lo_o=3, hi_o=1.
4. DIV 0x12345678 / 0 -> lo_o=0xFFFFFFFF, hi_o=0x12345678 after full latency. DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
5. Cancel and back-to-back:
   - start DIVU, then cancel=1 at cycle 10 -> busy=0 next cycle, no hilo_we, hi_o/lo_o unchanged.
   - Immediate new start -> accepted, correct result.
   - start pulsed while busy -> ignored.
6. Reset: assert cpu_rst asynchronously mid-CALC -> all outputs 0 without a clock edge. After release, start MULTU 2 x 3 -> lo_o=6, hi_o=0.
